// File: rtl/spi_pkg.sv
// Shared types for the SPI transmit engine: FSM states, mode bit layout and
// the bit-count field width derivation.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    EOT
  } spi_state_e;

  // A mode number packs {cpol, cpha}, so SPI_MODE3 is cpol=1, cpha=1.
  typedef logic [1:0] spi_mode_t;
  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;
  localparam spi_mode_t SPI_MODE0 = 2'b00;
  localparam spi_mode_t SPI_MODE1 = 2'b01;
  localparam spi_mode_t SPI_MODE2 = 2'b10;
  localparam spi_mode_t SPI_MODE3 = 2'b11;

  function automatic int lenWidth(input int maxBits);
    return (maxBits > 1) ? $clog2(maxBits) : 1;
  endfunction

endpackage

// File: rtl/spi_tx_engine_if.sv
// Word handshake between the TX front end (master) and the serializer (slave).
interface spi_tx_engine_if
  import spi_pkg::*;
#(
  parameter int WIDTH = 32 + lenWidth(32)
);

  logic [WIDTH-1:0] tx_data;
  logic             tx_vld;
  logic             tx_rdy;
  logic             tx_eot;

  modport master (
    output tx_data,
    output tx_vld,
    input  tx_rdy,
    input  tx_eot
  );

  modport slave (
    input  tx_data,
    input  tx_vld,
    output tx_rdy,
    output tx_eot
  );

endinterface

// File: rtl/spi_clk_gen.sv
// Half-period timebase and SPI bus clock. Outside a transfer the bus clock
// tracks the idle level; during a transfer it toggles on every half_en.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_r,
  input  logic rstn_r,
  input  logic active,
  input  logic idleLevel,
  output logic halfEn,
  output logic spi_bus_clk
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] divCnt_q;
  logic             sclk_q;

  assign halfEn      = active && (divCnt_q == CNT_LAST);
  assign spi_bus_clk = sclk_q;

  // Loading the live idle level while inactive also captures cpol on the
  // acceptance edge, since the engine is not yet shifting at that point.
  always_ff @(posedge clk_r or posedge rstn_r) begin
    if (rstn_r) begin
      divCnt_q <= '0;
      sclk_q   <= 1'b0;
    end else if (!active) begin
      divCnt_q <= '0;
      sclk_q   <= idleLevel;
    end else if (halfEn) begin
      divCnt_q <= '0;
      sclk_q   <= ~sclk_q;
    end else begin
      divCnt_q <= divCnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_tx_engine.sv
// MSB-first SPI master transmit serializer with per-word bit count and all
// four clock modes; tx_eot pulses for one cycle after each word.
module spi_tx_engine
  import spi_pkg::*;
#(
  parameter int DLY          = 1,
  parameter int SPI_TX_WIDTH = 32,
  parameter int CLK_DIV      = 4,
  parameter int LEN_W        = lenWidth(SPI_TX_WIDTH),
  parameter int WIDTH        = SPI_TX_WIDTH + LEN_W
) (
  input  logic             clk_r,
  input  logic             rstn_r,
  input  logic             cpol,
  input  logic             cpoa,
  input  logic [LEN_W-1:0] length,
  spi_tx_engine_if.slave   txIf,
  output logic             sdo,
  output logic             spi_bus_clk
);

  // DLY only shapes timing in behavioural models; nothing here depends on it.
  if (DLY < 0 || CLK_DIV < 1) begin : gUnsupportedParams
  end

  spi_state_e              state_q, state_d;
  logic [SPI_TX_WIDTH-1:0] shiftReg_q, shiftReg_d;
  logic [LEN_W:0]          halfCnt_q, halfCnt_d;
  logic [LEN_W-1:0]        lastIdx_q, lastIdx_d;
  logic                    cpha_q, cpha_d;
  logic                    sdo_q, sdo_d;

  logic                    halfEn;
  logic                    accept;
  logic                    lastHalf;
  logic                    shiftEvt;
  logic [LEN_W-1:0]        reqIdx;
  logic [LEN_W-1:0]        wordIdx;
  logic [SPI_TX_WIDTH-1:0] payload;
  logic [SPI_TX_WIDTH-1:0] aligned;

  assign reqIdx  = txIf.tx_data[WIDTH-1:SPI_TX_WIDTH];
  assign payload = txIf.tx_data[SPI_TX_WIDTH-1:0];
  assign wordIdx = (reqIdx < length) ? reqIdx : length;
  assign aligned = payload << (LEN_W'(SPI_TX_WIDTH - 1) - wordIdx);
  assign accept  = txIf.tx_vld && (state_q != SHIFT);

  // Half periods are numbered from 0; even ones end in a leading edge, odd
  // ones in a trailing edge, and the last is 2N-1 = {N-1, 1}.
  assign lastHalf = (halfCnt_q == {lastIdx_q, 1'b1});
  assign shiftEvt = halfEn && (cpha_q ? !halfCnt_q[0] : (halfCnt_q[0] && !lastHalf));

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) uClkGen (
    .clk_r       (clk_r),
    .rstn_r      (rstn_r),
    .active      (state_q == SHIFT),
    .idleLevel   (cpol),
    .halfEn      (halfEn),
    .spi_bus_clk (spi_bus_clk)
  );

  assign txIf.tx_rdy = (state_q != SHIFT);
  assign txIf.tx_eot = (state_q == EOT);
  assign sdo         = sdo_q;

  always_ff @(posedge clk_r or posedge rstn_r) begin
    if (rstn_r) begin
      state_q    <= IDLE;
      shiftReg_q <= '0;
      halfCnt_q  <= '0;
      lastIdx_q  <= '0;
      cpha_q     <= 1'b0;
      sdo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shiftReg_q <= shiftReg_d;
      halfCnt_q  <= halfCnt_d;
      lastIdx_q  <= lastIdx_d;
      cpha_q     <= cpha_d;
      sdo_q      <= sdo_d;
    end
  end

  // With CPHA=0 the MSB must already be on sdo before the first leading
  // edge, so it is presented straight from the acceptance edge.
  always_comb begin
    state_d    = state_q;
    shiftReg_d = shiftReg_q;
    halfCnt_d  = halfCnt_q;
    lastIdx_d  = lastIdx_q;
    cpha_d     = cpha_q;
    sdo_d      = sdo_q;
    case (state_q)
      IDLE, EOT: begin
        sdo_d   = 1'b0;
        state_d = IDLE;
        if (accept) begin
          state_d   = SHIFT;
          cpha_d    = cpoa;
          lastIdx_d = wordIdx;
          halfCnt_d = '0;
          if (cpoa) begin
            shiftReg_d = aligned;
          end else begin
            shiftReg_d = aligned << 1;
            sdo_d      = aligned[SPI_TX_WIDTH-1];
          end
        end
      end
      SHIFT: begin
        if (halfEn) begin
          halfCnt_d = halfCnt_q + 1'b1;
          if (lastHalf) begin
            state_d = EOT;
          end
        end
        if (shiftEvt) begin
          sdo_d      = shiftReg_q[SPI_TX_WIDTH-1];
          shiftReg_d = shiftReg_q << 1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_tx_engine.sv
// Self-checking bench for spi_tx_engine: a CLK_DIV=4 and a CLK_DIV=1 instance,
// each word checked against a word-level model of bit order, count and timing.
module tb_spi_tx_engine;
  import spi_pkg::*;

  localparam int TX_W = 32;
  localparam int LW   = lenWidth(TX_W);
  localparam int DW   = TX_W + LW;

  logic          clk_r = 1'b0;
  logic          rstn_r;
  logic          cpol;
  logic          cpoa;
  logic          selB;
  logic          txVld;
  logic [LW-1:0] length;
  logic [DW-1:0] txData;
  logic          sdoA, sdoB, sclkA, sclkB;
  logic          obsRdy, obsEot, obsSdo, obsClk;
  int            vectors = 0;
  int            miscompares = 0;

  spi_tx_engine_if #(.WIDTH(DW)) txIfA ();
  spi_tx_engine_if #(.WIDTH(DW)) txIfB ();

  assign txIfA.tx_data = txData;
  assign txIfB.tx_data = txData;
  assign txIfA.tx_vld  = txVld & ~selB;
  assign txIfB.tx_vld  = txVld & selB;

  spi_tx_engine #(.SPI_TX_WIDTH(TX_W), .CLK_DIV(4)) dutA (
    .clk_r       (clk_r),
    .rstn_r      (rstn_r),
    .cpol        (cpol),
    .cpoa        (cpoa),
    .length      (length),
    .txIf        (txIfA),
    .sdo         (sdoA),
    .spi_bus_clk (sclkA)
  );

  spi_tx_engine #(.SPI_TX_WIDTH(TX_W), .CLK_DIV(1)) dutB (
    .clk_r       (clk_r),
    .rstn_r      (rstn_r),
    .cpol        (cpol),
    .cpoa        (cpoa),
    .length      (length),
    .txIf        (txIfB),
    .sdo         (sdoB),
    .spi_bus_clk (sclkB)
  );

  always #5 clk_r = ~clk_r;

  always_comb begin
    obsRdy = selB ? txIfB.tx_rdy : txIfA.tx_rdy;
    obsEot = selB ? txIfB.tx_eot : txIfA.tx_eot;
    obsSdo = selB ? sdoB : sdoA;
    obsClk = selB ? sclkB : sclkA;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expected);
    vectors++;
    if (got !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expected);
    end
  endtask

  // Called at a falling edge: sets the idle clock level and checks idle outputs.
  task automatic idleCheck(input logic sel, input logic cpolV);
    selB  = sel;
    cpol  = cpolV;
    txVld = 1'b0;
    @(negedge clk_r);
    @(negedge clk_r);
    checkOutput("idleClk", 64'(obsClk), 64'(cpolV));
    checkOutput("idleSdo", 64'(obsSdo), 64'd0);
    checkOutput("idleRdy", 64'(obsRdy), 64'd1);
    checkOutput("idleEot", 64'(obsEot), 64'd0);
  endtask

  // Called at a falling edge with the engine ready. Acts as an SPI slave that
  // samples sdo as it was just before each capture edge of spi_bus_clk.
  task automatic applyStimulus(input logic sel, input logic cpolV, input logic cphaV,
                               input logic [LW-1:0] lenV, input logic [LW-1:0] reqV,
                               input logic [TX_W-1:0] payV, input logic holdVld,
                               input int abortAt);
    int          div, n, expEot, budget, cnt, toggles, lastTog, bits;
    logic        prevClk, prevSdo, done, spacingOk, rdyOk, stableOk, capture, eotSeen;
    logic [31:0] rx, expData;
    div     = sel ? 1 : 4;
    n       = ((reqV < lenV) ? int'(reqV) : int'(lenV)) + 1;
    expData = (n == 32) ? payV : (payV & ((32'd1 << n) - 32'd1));
    expEot  = 2 * n * div + 1;
    budget  = expEot + 20;
    checkOutput("rdyBeforeAccept", 64'(obsRdy), 64'd1);
    selB   = sel;
    cpol   = cpolV;
    cpoa   = cphaV;
    length = lenV;
    txData = {reqV, payV};
    txVld  = 1'b1;
    @(posedge clk_r);
    cnt = 0; toggles = 0; lastTog = 0; bits = 0; rx = '0;
    done = 1'b0; spacingOk = 1'b1; rdyOk = 1'b1; stableOk = 1'b1;
    prevClk = cpolV;
    prevSdo = 1'b0;
    while (!done && cnt < budget) begin
      @(negedge clk_r);
      cnt++;
      if (!holdVld) begin
        txVld  = 1'b0;
        txData = DW'({$urandom(), $urandom()});
        cpol   = 1'($urandom_range(1, 0));
        cpoa   = 1'($urandom_range(1, 0));
        length = LW'($urandom_range(31, 0));
      end
      if (abortAt > 0 && cnt == abortAt) begin
        txVld = 1'b0;
        #2 rstn_r = 1'b1;
        #1;
        checkOutput("abortRdy", 64'(obsRdy), 64'd1);
        checkOutput("abortSdo", 64'(obsSdo), 64'd0);
        checkOutput("abortClk", 64'(obsClk), 64'd0);
        eotSeen = obsEot;
        repeat (3) begin
          @(negedge clk_r);
          eotSeen = eotSeen | obsEot;
        end
        checkOutput("abortNoEot", 64'(eotSeen), 64'd0);
        rstn_r = 1'b0;
        return;
      end
      if (cnt == 1) begin
        checkOutput("clkAtAccept", 64'(obsClk), 64'(cpolV));
        if (!cphaV) checkOutput("msbAtAccept", 64'(obsSdo), 64'(expData[n-1]));
      end
      if (obsClk !== prevClk) begin
        toggles++;
        if (toggles == 1) begin
          if (cnt != div + 1) spacingOk = 1'b0;
        end else if (cnt - lastTog != div) begin
          spacingOk = 1'b0;
        end
        lastTog = cnt;
        capture = cphaV ? (obsClk == cpolV) : (obsClk != cpolV);
        if (capture) begin
          rx = {rx[30:0], prevSdo};
          bits++;
          if (obsSdo !== prevSdo) stableOk = 1'b0;
        end
      end
      if (obsEot === 1'b1) done = 1'b1;
      else if (obsRdy !== 1'b0) rdyOk = 1'b0;
      prevClk = obsClk;
      prevSdo = obsSdo;
    end
    checkOutput("eotSeen", 64'(done), 64'd1);
    checkOutput("eotCycle", 64'(cnt), 64'(expEot));
    checkOutput("halfPeriods", 64'(toggles), 64'(2 * n));
    checkOutput("halfSpacing", 64'(spacingOk), 64'd1);
    checkOutput("bitCount", 64'(bits), 64'(n));
    checkOutput("data", 64'(rx), 64'(expData));
    checkOutput("stableAtSample", 64'(stableOk), 64'd1);
    checkOutput("rdyLowInShift", 64'(rdyOk), 64'd1);
    checkOutput("clkEndLevel", 64'(obsClk), 64'(cpolV));
  endtask

  initial begin
    spi_mode_t modes[3];
    spi_mode_t m;
    logic      prevHold, hold, sel;
    modes  = '{SPI_MODE0, SPI_MODE1, SPI_MODE2};
    rstn_r = 1'b1;
    cpol   = 1'b1;
    cpoa   = 1'b0;
    length = LW'(31);
    txVld  = 1'b0;
    txData = '0;
    selB   = 1'b0;
    #1;
    checkOutput("resetRdy", 64'(obsRdy), 64'd1);
    checkOutput("resetEot", 64'(obsEot), 64'd0);
    checkOutput("resetSdo", 64'(obsSdo), 64'd0);
    checkOutput("resetClkA", 64'(sclkA), 64'd0);
    checkOutput("resetClkB", 64'(sclkB), 64'd0);
    repeat (3) @(negedge clk_r);
    rstn_r = 1'b0;
    idleCheck(1'b0, 1'b1);
    idleCheck(1'b0, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b1, LW'(31), LW'(31), 32'hA5A5_0F0F, 1'b0, 0);
    idleCheck(1'b0, 1'b1);
    foreach (modes[i]) begin
      applyStimulus(1'b0, modes[i][CPOL_BIT], modes[i][CPHA_BIT], LW'(31), LW'(31),
                    32'h8000_0001, 1'b0, 0);
      idleCheck(1'b0, modes[i][CPOL_BIT]);
    end

    applyStimulus(1'b0, 1'b0, 1'b0, LW'(31), LW'(7), 32'h0000_00C3, 1'b0, 0);
    idleCheck(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, LW'(7), LW'(31), $urandom, 1'b0, 0);
    idleCheck(1'b0, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b1, LW'(31), LW'(15), $urandom, 1'b1, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, LW'(31), LW'(9), $urandom, 1'b1, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, LW'(31), LW'(31), $urandom, 1'b1, 0);
    txVld = 1'b0;
    idleCheck(1'b0, 1'b1);

    applyStimulus(1'b0, 1'b1, 1'b0, LW'(31), LW'(31), $urandom, 1'b0, 84);
    applyStimulus(1'b0, 1'b0, 1'b1, LW'(31), LW'(31), 32'h1234_5678, 1'b0, 0);
    idleCheck(1'b0, 1'b0);

    idleCheck(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, LW'(31), LW'(31), $urandom, 1'b0, 0);
    idleCheck(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, LW'(31), LW'(31), $urandom, 1'b0, 0);
    idleCheck(1'b1, 1'b0);

    prevHold = 1'b0;
    sel      = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!prevHold) begin
        sel = 1'($urandom_range(1, 0));
        idleCheck(sel, 1'($urandom_range(1, 0)));
      end
      m    = spi_mode_t'($urandom_range(3, 0));
      hold = (i != 15) && ($urandom_range(3, 0) == 0);
      applyStimulus(sel, m[CPOL_BIT], m[CPHA_BIT], LW'($urandom_range(31, 0)),
                    LW'($urandom_range(31, 0)), $urandom, hold, 0);
      if (!hold) txVld = 1'b0;
      prevHold = hold;
    end
    txVld = 1'b0;
    idleCheck(sel, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900_000;
    $display("[TB] FAIL watchdog: simulation did not finish, vectors %0d miscompares %0d",
             vectors, miscompares);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
